serial_sum_collector: RTL
=========================

SERIAL_SUM_COLLECTOR -- requirements
Module: serial_sum_collector

Interface
REQ-001 Parameter: WIDTH, default 8, number of serial sum bits per frame (legal range 2..32).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start_i  input  1  begin a new frame; clears the collector and bit counter.
REQ-005 Port: bit_valid_i  input  1  sum_i/carry_i carry a valid bit this cycle (adder enable).
REQ-006 Port: sum_i  input  1  serial sum bit, LSB first.
REQ-007 Port: carry_i  input  1  adder carry-out associated with the current sum bit.
REQ-008 Port: result_ready_i  input  1  consumer accepts result this cycle.
REQ-009 Port: result_o  output  WIDTH  assembled parallel sum.
REQ-010 Port: carry_o  output  1  final carry, i.e. carry_i sampled with the last bit of the frame.
REQ-011 Port: result_valid_o  output  1  result_o/carry_o valid; held until accepted.
REQ-012 Port: busy_o  output  1  high while a frame is being collected.

Function
REQ-013 FSM has exactly three states: IDLE, COLLECT, HOLD.
REQ-014 IDLE: bit_valid_i ignored; start_i=1 -> COLLECT, with shift register, bit counter and carry register cleared.
REQ-015 COLLECT: each cycle with bit_valid_i=1 shifts right, sum_i entering bit WIDTH-1, and increments the counter; cycles with bit_valid_i=0 hold all state.
REQ-016 On the WIDTH-th accepted bit: capture carry_i into carry_o, load result_o from the completed shift value and go to HOLD, so result_valid_o rises the cycle after the last bit (latency 1).
REQ-017 start_i in COLLECT aborts the frame: clear state and restart counting, staying in COLLECT; if start_i and bit_valid_i are both set, start_i wins and the bit is dropped.
REQ-018 HOLD: result_valid_o=1 and result_o/carry_o are stable; bit_valid_i is ignored.
REQ-019 HOLD with result_ready_i=1 -> IDLE; with result_ready_i=1 and start_i=1 in the same cycle -> COLLECT (cleared), no idle bubble.
REQ-020 HOLD with start_i=1 and result_ready_i=0: start_i is ignored and the result is never overwritten before acceptance.
REQ-021 busy_o=1 exactly in COLLECT; result_valid_o=1 exactly in HOLD.
REQ-022 Bit counter width is clog2(WIDTH)+1; the terminal compare is against WIDTH-1 on the accepting cycle, with no wrap-around past WIDTH.
REQ-023 result_o and carry_o retain their last values in IDLE and COLLECT until the next completed frame.

Reset
REQ-024 rst_n=0 asynchronously forces: state=IDLE, result_o=0, carry_o=0, result_valid_o=0, busy_o=0, counter=0, shift register=0.
REQ-025 Reset asserted mid-frame or in HOLD discards the partial or pending result; no output pulse follows reset release.
REQ-026 The first active edge after rst_n deasserts is a normal operating cycle.

Structure
REQ-027 A shared package or include holds the FSM state encodings (IDLE=0, COLLECT=1, HOLD=2) and the default WIDTH constant, shared with the serial adder top.
REQ-028 One natural sub-module: sipo_shift_register (serial-in/parallel-out, enable, synchronous clear), the inverse of the existing parallel-load shift register; everything else is inline.
REQ-029 Integrates directly with the serial full adder: sum_out->sum_i, carry_out->carry_i, enable->bit_valid_i.

Verification
REQ-030 0x5A+0x3C: start, then bits 0,1,1,0,1,0,0,1 with carry on the last bit=0 -> result_o=0x96, carry_o=0, result_valid_o high one cycle after the 8th bit.
REQ-031 0xFF+0x01: eight sum bits=0, carry on the last bit=1 -> result_o=0x00, carry_o=1.
REQ-032 Gapped bit_valid_i (every other cycle) with the same 0x96 stream -> identical result, busy_o high throughout, valid after the 8th accepted bit.
REQ-033 start_i after 5 bits, then a full 0x96 stream -> result 0x96, the first 5 bits discarded.
REQ-034 HOLD with result_ready_i=0 for 10 cycles plus start_i pulses -> result stable; then ready+start in the same cycle -> COLLECT next cycle.
REQ-035 rst_n low asynchronously mid-frame (between clock edges) -> all outputs 0 immediately; no valid after release without a new start_i.

Source files
------------

// File: rtl/serial_sum_collector_pkg.sv
// Shared constants and FSM encoding for the serial adder / sum collector slice.
package serial_sum_collector_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sum_collector_if.sv
// Bit-stream input and result handshake between serial adder, collector and consumer.
interface serial_sum_collector_if
    import serial_sum_collector_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start_i;
    logic             bit_valid_i;
    logic             sum_i;
    logic             carry_i;
    logic             result_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             carry_o;
    logic             result_valid_o;
    logic             busy_o;

    modport slave (
        input  start_i, bit_valid_i, sum_i, carry_i, result_ready_i,
        output result_o, carry_o, result_valid_o, busy_o
    );

    modport master (
        output start_i, bit_valid_i, sum_i, carry_i, result_ready_i,
        input  result_o, carry_o, result_valid_o, busy_o
    );
endinterface

// File: rtl/serial_sum_collector_sipo_shift_register.sv
// Serial-in/parallel-out shift register: LSB-first input enters at the MSB and shifts right.
module sipo_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);
    // q_next lets the owner capture the completed word on the same edge as the last shift
    assign q_next = {din, q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= q_next;
    end
endmodule

// File: rtl/serial_sum_collector.sv
// Collects a serial adder's LSB-first sum stream into a parallel word with final carry,
// presenting it on a valid/ready handshake.
module serial_sum_collector
    import serial_sum_collector_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_sum_collector_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             clr;
    logic             shift_en;
    logic             done;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;

    sipo_shift_register #(.WIDTH(WIDTH)) u_sipo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .en     (shift_en),
        .din    (bus.sum_i),
        .q      (sh_q),
        .q_next (sh_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        shift_en  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    clr       = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                // start_i aborts and wins over a coincident bit
                if (bus.start_i) begin
                    clr = 1'b1;
                end else if (bus.bit_valid_i) begin
                    shift_en = 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        done      = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                // start_i only counts once the pending result is accepted
                if (bus.result_ready_i) begin
                    if (bus.start_i) begin
                        clr       = 1'b1;
                        state_nxt = COLLECT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (shift_en)
            cnt <= cnt + CW'(1);
    end

    // Result and carry persist through IDLE/COLLECT until the next frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
        end else if (done) begin
            result_q <= sh_next;
            carry_q  <= bus.carry_i;
        end
    end

    assign bus.result_o       = result_q;
    assign bus.carry_o        = carry_q;
    assign bus.result_valid_o = (state == HOLD);
    assign bus.busy_o         = (state == COLLECT);

endmodule
